alu_pipe: RTL and testbench

//   Parametrised, two-stage pipelined ALU. Successor to the fixed 4-bit combinational ALU.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_pipe_dp.sv | 82 ++++++++
 rtl/alu_pipe.sv | 112 +++++++++++
 tb/tb_alu_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU.
package alu_pkg;

    localparam int FLAGS_W = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_ACC = 3'd7;

    localparam int F_C = 3;
    localparam int F_Z = 2;
    localparam int F_N = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/alu_pipe_dp.sv
// Combinational ALU datapath: result, {C,Z,N,V} and next accumulator.
module alu_pipe_dp
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit ACC_EN = 1'b1
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags,
    output logic [WIDTH-1:0]   acc_next
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;
    localparam logic [WIDTH-1:0] WMOD = WIDTH[WIDTH-1:0];

    logic [SH_W-1:0] sh;
    logic [WIDTH:0]  sum, dif, accs, shl_w, shr_w;
    logic            c, v;

    assign sh    = SH_W'(b % WMOD);
    assign sum   = {1'b0, a} + {1'b0, b};
    assign dif   = {1'b0, a} - {1'b0, b};
    assign accs  = {1'b0, acc} + {1'b0, a};
    // Extra bit on each side catches the last bit shifted out.
    assign shl_w = {1'b0, a} << sh;
    assign shr_w = {a, 1'b0} >> sh;

    always_comb begin
        result   = '0;
        c        = 1'b0;
        v        = 1'b0;
        acc_next = acc;
        unique case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = dif[WIDTH-1:0];
                c      = dif[WIDTH];
                v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_w[WIDTH-1:0];
                c      = shl_w[WIDTH];
            end
            OP_SHR: begin
                result = shr_w[WIDTH:1];
                c      = shr_w[0];
            end
            OP_ACC: begin
                if (ACC_EN) begin
                    result   = accs[WIDTH-1:0];
                    c        = accs[WIDTH];
                    v        = (acc[MSB] == a[MSB]) && (result[MSB] != acc[MSB]);
                    acc_next = result;
                end else begin
                    result = a;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        flags      = '0;
        flags[F_C] = c;
        flags[F_Z] = (result == '0);
        flags[F_N] = result[MSB];
        flags[F_V] = v;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with accumulator and valid/ready handshakes.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit ACC_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags,
    output logic [WIDTH-1:0]   acc_out
);

    logic               s1_v_q, s1_v_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               ov_q, ov_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [FLAGS_W-1:0] fl_q, fl_d;
    logic [WIDTH-1:0]   acc_q, acc_d;

    logic [WIDTH-1:0]   dp_res, dp_acc;
    logic [FLAGS_W-1:0] dp_fl;
    logic               s2_load, accept;

    alu_pipe_dp #(
        .WIDTH  (WIDTH),
        .ACC_EN (ACC_EN)
    ) u_dp (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .acc      (acc_q),
        .result   (dp_res),
        .flags    (dp_fl),
        .acc_next (dp_acc)
    );

    assign s2_load  = en && s1_v_q && (!ov_q || out_ready);
    assign in_ready = !rst && en && (!s1_v_q || s2_load);
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_v_d = s1_v_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        ov_d   = ov_q;
        res_d  = res_q;
        fl_d   = fl_q;
        acc_d  = acc_q;
        if (accept) begin
            s1_v_d = 1'b1;
            op_d   = op;
            a_d    = in_a;
            b_d    = in_b;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end
        if (s2_load) begin
            ov_d  = 1'b1;
            res_d = dp_res;
            fl_d  = dp_fl;
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        // A clear beats a coincident ACC write; the ACC result still used the old value.
        if (acc_clr) begin
            acc_d = '0;
        end else if (s2_load) begin
            acc_d = dp_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ov_q   <= 1'b0;
            res_q  <= '0;
            fl_q   <= '0;
            acc_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ov_q   <= ov_d;
            res_q  <= res_d;
            fl_q   <= fl_d;
            acc_q  <= acc_d;
        end
    end

    assign out_valid = ov_q;
    assign result    = res_q;
    assign flags     = fl_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 4;
    localparam int M = 16;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, in_ready, acc_clr;
    logic         out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] in_a, in_b, result, acc_out;
    logic [3:0]   flags;

    typedef struct {
        int res;
        int fl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   macc   = 0;

    alu_pipe #(.WIDTH(W), .ACC_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= H) ? x - M : x;
    endfunction

    function automatic void model(input int o, input int a, input int b,
                                  inout int acc, output int res, output int fl);
        int s, sv, sh, c, v;
        c = 0;
        v = 0;
        sh = b % W;
        case (o)
            0: begin
                s = a + b; res = s % M; c = (s >= M) ? 1 : 0;
                sv = sgn(a) + sgn(b); v = (sv >= H || sv < -H) ? 1 : 0;
            end
            1: begin
                res = (a - b + M) % M; c = (a < b) ? 1 : 0;
                sv = sgn(a) - sgn(b); v = (sv >= H || sv < -H) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin
                res = (a << sh) % M;
                c = (sh != 0) ? ((a >> (W - sh)) & 1) : 0;
            end
            6: begin
                res = a >> sh;
                c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0;
            end
            default: begin
                s = acc + a; res = s % M; c = (s >= M) ? 1 : 0;
                sv = sgn(acc) + sgn(a); v = (sv >= H || sv < -H) ? 1 : 0;
                acc = res;
            end
        endcase
        fl = c * 8 + ((res == 0) ? 4 : 0) + ((res >= H) ? 2 : 0) + v;
    endfunction

    // One clock: score any output transfer and any accept, then advance.
    task automatic cyc(output bit got);
        int   r, f;
        exp_t e;
        #1;
        got = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_flags", flags, e.fl);
            end
        end
        if (got) begin
            model(int'(op), int'(in_a), int'(in_b), macc, r, f);
            q.push_back('{r, f});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int o, input int a, input int b);
        bit g;
        int n;
        n = 0;
        op = 3'(o);
        in_a = W'(a);
        in_b = W'(b);
        in_valid = 1'b1;
        do begin
            cyc(g);
            n++;
        end while (!g && n < 20);
        if (!g) chk("issue_timeout", 0, 1);
    endtask

    task automatic drain();
        bit g;
        int n;
        n = 0;
        in_valid = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            cyc(g);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_idle", out_valid, 0);
    endtask

    initial begin
        bit g;
        exp_t e0;

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        acc_clr = 1'b0; op = '0; in_a = '0; in_b = '0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);

        // ADD with overflow and carry, latency check
        op = 3'd0; in_a = 4'd9; in_b = 4'd8; in_valid = 1'b1;
        cyc(g);
        chk("add_accept", g, 1);
        chk("add_lat1", out_valid, 0);
        in_valid = 1'b0;
        cyc(g);
        chk("add_lat2", out_valid, 1);
        chk("add_res", result, 4'h1);
        chk("add_flags", flags, 4'b1001);

        issue(1, 3, 5);
        in_valid = 1'b0;
        cyc(g);
        chk("sub_res", result, 4'hE);
        chk("sub_flags", flags, 4'b1010);
        issue(1, 5, 5);
        in_valid = 1'b0;
        cyc(g);
        chk("sub0_res", result, 4'h0);
        chk("sub0_flags", flags, 4'b0100);

        issue(5, 4'b1011, 1);
        in_valid = 1'b0;
        cyc(g);
        chk("shl_res", result, 4'b0110);
        chk("shl_flags", flags, 4'b1000);
        issue(6, 4'b1011, 4);
        in_valid = 1'b0;
        cyc(g);
        chk("shr_res", result, 4'b1011);
        chk("shr_flags", flags, 4'b0010);
        drain();

        // Random traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            en        = ($urandom % 5) != 0;
            op        = 3'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            cyc(g);
        end
        drain();

        // Accumulator chain and clear collision
        acc_clr = 1'b1;
        cyc(g);
        acc_clr = 1'b0;
        macc = 0;
        chk("clr_acc", acc_out, 0);
        issue(7, 3, 0);
        issue(7, 7, 0);
        issue(7, 8, 0);
        in_valid = 1'b0;
        chk("acc2_res", result, 4'hA);
        cyc(g);
        chk("acc3_res", result, 4'h2);
        chk("acc3_c", flags[3], 1);
        chk("acc3_out", acc_out, 4'h2);
        issue(7, 1, 0);
        in_valid = 1'b0;
        acc_clr = 1'b1;
        cyc(g);
        acc_clr = 1'b0;
        macc = 0;
        chk("accclr_res", result, 4'h3);
        chk("accclr_acc", acc_out, 0);
        drain();

        // Backpressure holds two ops
        out_ready = 1'b0;
        issue($urandom % 8, $urandom % 16, $urandom % 16);
        issue($urandom % 8, $urandom % 16, $urandom % 16);
        op = 3'd4; in_a = 4'h5; in_b = 4'hC; in_valid = 1'b1;
        chk("bp_in_ready", in_ready, 0);
        e0 = q[0];
        for (int i = 0; i < 2; i++) begin
            cyc(g);
            chk("bp_no_accept", g, 0);
            chk("bp_hold_res", result, e0.res);
            chk("bp_hold_flags", flags, e0.fl);
        end
        out_ready = 1'b1;
        issue(4, 5, 12);
        drain();

        // en low mid-stream: drain continues, nothing advances
        out_ready = 1'b0;
        issue(0, 7, 7);
        issue(3, 2, 9);
        op = 3'd1; in_a = 4'h2; in_b = 4'h1; in_valid = 1'b1;
        en = 1'b0;
        cyc(g);
        chk("en0_no_accept", g, 0);
        chk("en0_in_ready", in_ready, 0);
        out_ready = 1'b1;
        cyc(g);
        chk("en0_drained", out_valid, 0);
        cyc(g);
        chk("en0_no_accept2", g, 0);
        en = 1'b1;
        issue(1, 2, 1);
        drain();

        // Reset with ops in flight
        acc_clr = 1'b1;
        cyc(g);
        acc_clr = 1'b0;
        macc = 0;
        issue(7, 5, 0);
        drain();
        chk("pre_rst_acc", acc_out, 5);
        out_ready = 1'b0;
        issue(0, 1, 2);
        issue(1, 6, 3);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_acc", acc_out, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_result", result, 0);
        #1 rst = 1'b0;
        q.delete();
        macc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(g);
            chk("post_rst_quiet", out_valid, 0);
        end
        issue(0, 2, 3);
        in_valid = 1'b0;
        cyc(g);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_res", result, 4'h5);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
